// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
//   Shared definitions for the ALU sharing arbiter:
//     - FSM state encoding (IDLE / EXEC / RESP)
//     - default operand and control widths
//     - requester index constants and a small index-to-one-hot helper
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CTRL_W = 4;

    // Requester 0 is the core datapath, requester 1 the auxiliary engine.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_share_rr_pick
//   Combinational two-way picker for the ALU sharing arbiter.
//   Default build: round-robin. With both requesters valid, the one that did
//   not win last time wins; with a single requester valid, it wins.
//   Build macro ALU_ARB_CORE_PRIORITY_EN: fixed priority, requester 0 wins
//   whenever it is valid and last_gnt is ignored.
//
// Ports:
//   req_valid [1:0]  per-requester request valid
//   last_gnt         index of the previous winner
//   grant     [1:0]  one-hot grant, all zero when nobody is valid
//   winner           index of the winning requester (valid only if grant != 0)
// -----------------------------------------------------------------------------
module alu_share_rr_pick
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_gnt,
    output logic [1:0] grant,
    output logic       winner
);

`ifdef ALU_ARB_CORE_PRIORITY_EN
    // The pointer has no meaning under fixed priority.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        // NOTE: every output gets a default before any branch so that no
        // path through the block leaves it unassigned (which would infer a latch).
        winner = REQ_CORE;
        grant  = 2'b00;
`ifdef ALU_ARB_CORE_PRIORITY_EN
        if (!req_valid[0]) begin
            winner = REQ_AUX;
        end
`else
        if (req_valid == 2'b11) begin
            winner = ~last_gnt;
        end else if (req_valid == 2'b10) begin
            winner = REQ_AUX;
        end
`endif
        if (|req_valid) begin
            grant = idx_to_onehot(winner);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one ALU (and its operand-B mux) between the core datapath
//   (requester 0) and an auxiliary engine (requester 1). An accepted request
//   is latched into operand registers, executed for exactly one cycle, and the
//   registered result is returned on a valid/ready response handshake.
//   One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//
//   Build macro ALU_ARB_CORE_PRIORITY_EN selects fixed priority (requester 0
//   always wins) instead of round-robin; see alu_share_rr_pick.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake
//   req_a/req_b/req_imm   per-requester operands, slice i = [i*DATA_W +: DATA_W]
//   req_src               per-requester operand-B select (1 = immediate)
//   req_ctrl              per-requester ALU control, slice i = [i*CTRL_W +: CTRL_W]
//   alu_a/alu_src_1/alu_src_2/alu_src/alu_ctrl   drive to operand mux and ALU
//   alu_result            combinational result from the ALU
//   resp_valid/resp_ready per-requester response handshake
//   resp_data             registered result for the granted requester
//   busy                  high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*DATA_W-1:0] req_imm,
    input  logic [1:0]          req_src,
    input  logic [2*CTRL_W-1:0] req_ctrl,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_src_1,
    output logic [DATA_W-1:0]   alu_src_2,
    output logic                alu_src,
    output logic [CTRL_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0]   alu_result,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                busy
);

    arb_state_t state;
    arb_state_t state_next;

    logic              gnt;
    logic              last_gnt;
    logic [1:0]        pick_grant;
    logic              pick_idx;
    logic              accept;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_imm;
    logic              op_src;
    logic [CTRL_W-1:0] op_ctrl;

    alu_share_rr_pick u_pick (
        .req_valid (req_valid),
        .last_gnt  (last_gnt),
        .grant     (pick_grant),
        .winner    (pick_idx)
    );

    assign accept = |(req_valid & req_ready);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        // NOTE: clocked state is written with non-blocking assignments so all
        // registers update together from values sampled before the edge.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)          state_next = EXEC;
            EXEC:                      state_next = RESP;
            RESP: if (resp_ready[gnt]) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = (state != IDLE);
        // The grant is offered only in IDLE and never while reset is held.
        if (state == IDLE && !reset) begin
            req_ready = pick_grant;
        end
        if (state == RESP) begin
            resp_valid = idx_to_onehot(gnt);
        end
    end

    // ------------------------------------------------------ last-grant pointer
`ifdef ALU_ARB_CORE_PRIORITY_EN
    assign last_gnt = REQ_AUX;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= REQ_AUX;  // requester 0 wins the first tie
        end else if (accept) begin
            last_gnt <= pick_idx;
        end
    end
`endif

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= REQ_CORE;
            op_a      <= '0;
            op_b      <= '0;
            op_imm    <= '0;
            op_src    <= 1'b0;
            op_ctrl   <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                gnt     <= pick_idx;
                op_a    <= pick_idx ? req_a[DATA_W +: DATA_W]   : req_a[0 +: DATA_W];
                op_b    <= pick_idx ? req_b[DATA_W +: DATA_W]   : req_b[0 +: DATA_W];
                op_imm  <= pick_idx ? req_imm[DATA_W +: DATA_W] : req_imm[0 +: DATA_W];
                op_src  <= req_src[pick_idx];
                op_ctrl <= pick_idx ? req_ctrl[CTRL_W +: CTRL_W] : req_ctrl[0 +: CTRL_W];
            end
            if (state == EXEC) begin
                resp_data <= alu_result;
            end
        end
    end

    // The ALU sees the operand registers in every state, so its inputs never
    // follow the raw requester buses.
    assign alu_a     = op_a;
    assign alu_src_1 = op_b;
    assign alu_src_2 = op_imm;
    assign alu_src   = op_src;
    assign alu_ctrl  = op_ctrl;

endmodule
